// File: rtl/serial_deser.sv
// rtl/serial_deser.sv - bit-serial to W-bit parallel receiver with framing check and one-entry output buffer
module serial_deser #(
  parameter int W         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sdi,
  input  logic         sframe,
  output logic [W-1:0] dout,
  output logic         valid,
  input  logic         ready,
  output logic         frame_err,
  output logic         ovr
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   sh_q, sh_d;
  logic [W-1:0]   dout_q, dout_d;
  logic           valid_q, valid_d;
  logic           ferr_q, ferr_d;
  logic           ovr_q, ovr_d;
  logic [W-1:0]   shifted;
  logic           word_done;

  always_comb begin
    shifted = MSB_FIRST ? {sh_q[W-2:0], sdi} : {sdi, sh_q[W-1:1]};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    dout_d    = dout_q;
    valid_d   = valid_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    word_done = 1'b0;

    case (state_q)
      IDLE: begin
        if (sframe) begin
          sh_d    = shifted;
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
      end
      default: begin
        if (sframe) begin
          sh_d = shifted;
          if (cnt_q == CW'(W - 1)) begin
            word_done = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          // cnt==0 here means a word just finished cleanly, so no error
          ferr_d  = (cnt_q != '0);
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
    endcase

    if (word_done) begin
      if (!valid_q || ready) begin
        dout_d  = shifted;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dout      = dout_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign ovr       = ovr_q;

endmodule

// File: tb/tb_serial_deser.sv
// tb/tb_serial_deser.sv - randomized self-checking bench for serial_deser (MSB-first and LSB-first instances)
module tb_serial_deser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       sdi = 1'b0;
  logic       sframe = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] dout_m, dout_l;
  logic       valid_m, valid_l, ferr_m, ferr_l, ovr_m, ovr_l;

  int checks = 0;
  int errors = 0;

  int         mbits[$];
  logic [7:0] e_dm, e_dl;
  logic       e_valid, e_ferr, e_ovr;
  logic       ovr_seen, ferr_seen;

  serial_deser #(.W(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .sdi(sdi), .sframe(sframe),
    .dout(dout_m), .valid(valid_m), .ready(ready),
    .frame_err(ferr_m), .ovr(ovr_m)
  );

  serial_deser #(.W(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .sdi(sdi), .sframe(sframe),
    .dout(dout_l), .valid(valid_l), .ready(ready),
    .frame_err(ferr_l), .ovr(ovr_l)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mbits.delete();
    e_dm = 8'h00; e_dl = 8'h00;
    e_valid = 1'b0; e_ferr = 1'b0; e_ovr = 1'b0;
  endtask

  // Drive one cycle, advance the word-level model at the edge, sample 1 time unit later.
  task automatic step(input logic d, input logic f, input logic r);
    logic [7:0] wm, wl;
    logic done;
    sdi = d; sframe = f; ready = r;
    @(posedge clk);
    done = 1'b0; wm = 8'h00; wl = 8'h00;
    e_ferr = 1'b0; e_ovr = 1'b0;
    if (f) begin
      mbits.push_back(int'(d));
      if (mbits.size() == 8) begin
        for (int i = 0; i < 8; i++) begin
          wm = wm + 8'(mbits[i] << (7 - i));
          wl = wl + 8'(mbits[i] << i);
        end
        mbits.delete();
        done = 1'b1;
      end
    end else if (mbits.size() != 0) begin
      e_ferr = 1'b1;
      mbits.delete();
    end
    if (done) begin
      if (!e_valid || r) begin
        e_dm = wm; e_dl = wl; e_valid = 1'b1;
      end else begin
        e_ovr = 1'b1;
      end
    end else if (e_valid && r) begin
      e_valid = 1'b0;
    end
    #1;
    ovr_seen  = ovr_seen | ovr_m | ovr_l;
    ferr_seen = ferr_seen | ferr_m | ferr_l;
  endtask

  task automatic send_word(input logic [7:0] w, input logic r);
    for (int i = 7; i >= 0; i--) step(w[i], 1'b1, r);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({dout_m, dout_l, valid_m, valid_l, ferr_m, ferr_l, ovr_m, ovr_l} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h/%h v=%b%b fe=%b%b ovr=%b%b, expected all 0",
               dout_m, dout_l, valid_m, valid_l, ferr_m, ferr_l, ovr_m, ovr_l);
    end
    model_reset();
    ovr_seen = 1'b0; ferr_seen = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b1);
    checks++;
    if (valid_m !== 1'b0 || ferr_m !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_change: got valid=%b frame_err=%b, expected 0 0", valid_m, ferr_m);
    end
  endtask

  task automatic test_basic();
    send_word(8'hA5, 1'b0);
    checks++;
    if (dout_m !== 8'hA5 || valid_m !== 1'b1) begin
      errors++;
      $display("FAIL basic_word: got dout=%h valid=%b, expected a5 1", dout_m, valid_m);
    end
    checks++;
    if (dout_l !== e_dl) begin
      errors++;
      $display("FAIL basic_lsb: got %h expected %h", dout_l, e_dl);
    end
    repeat (3) step(1'b0, 1'b0, 1'b0);
    checks++;
    if (dout_m !== 8'hA5 || valid_m !== 1'b1) begin
      errors++;
      $display("FAIL basic_hold: got dout=%h valid=%b, expected a5 1", dout_m, valid_m);
    end
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if (valid_m !== 1'b0 || dout_m !== 8'hA5) begin
      errors++;
      $display("FAIL basic_drain: got valid=%b dout=%h, expected 0 a5", valid_m, dout_m);
    end
  endtask

  task automatic test_back_to_back();
    ovr_seen = 1'b0;
    send_word(8'h3C, 1'b1);
    checks++;
    if (dout_m !== 8'h3C || valid_m !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: got dout=%h valid=%b, expected 3c 1", dout_m, valid_m);
    end
    send_word(8'hC3, 1'b1);
    checks++;
    if (dout_m !== 8'hC3 || valid_m !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: got dout=%h valid=%b, expected c3 1", dout_m, valid_m);
    end
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if (ovr_seen !== 1'b0 || ferr_m !== 1'b0) begin
      errors++;
      $display("FAIL b2b_pulses: got ovr_seen=%b frame_err=%b, expected 0 0", ovr_seen, ferr_m);
    end
  endtask

  task automatic test_short_frame();
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'($urandom), 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (ferr_m !== 1'b1 || ferr_l !== 1'b1 || valid_m !== 1'b0) begin
      errors++;
      $display("FAIL short_err: got frame_err=%b%b valid=%b, expected 11 0", ferr_m, ferr_l, valid_m);
    end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (ferr_m !== 1'b0) begin
      errors++;
      $display("FAIL short_pulse_len: got frame_err=%b, expected 0", ferr_m);
    end
    send_word(8'h5A, 1'b0);
    checks++;
    if (dout_m !== 8'h5A || valid_m !== 1'b1) begin
      errors++;
      $display("FAIL short_recover: got dout=%h valid=%b, expected 5a 1", dout_m, valid_m);
    end
  endtask

  task automatic test_overrun();
    step(1'b0, 1'b0, 1'b1);
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    checks++;
    if (ovr_m !== 1'b1 || dout_m !== 8'h11 || valid_m !== 1'b1) begin
      errors++;
      $display("FAIL ovr_pulse: got ovr=%b dout=%h valid=%b, expected 1 11 1", ovr_m, dout_m, valid_m);
    end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (ovr_m !== 1'b0 || dout_m !== 8'h11) begin
      errors++;
      $display("FAIL ovr_after: got ovr=%b dout=%h, expected 0 11", ovr_m, dout_m);
    end
  endtask

  task automatic test_lsb_first();
    step(1'b0, 1'b0, 1'b1);
    send_word(8'h80, 1'b0);
    checks++;
    if (dout_l !== 8'h01 || valid_l !== 1'b1) begin
      errors++;
      $display("FAIL lsb_first: got dout=%h valid=%b, expected 01 1", dout_l, valid_l);
    end
    checks++;
    if (dout_m !== 8'h80) begin
      errors++;
      $display("FAIL lsb_msb_ref: got %h expected 80", dout_m);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({dout_m, dout_l, valid_m, valid_l, ferr_m, ferr_l, ovr_m, ovr_l} !== 20'h0) begin
      errors++;
      $display("FAIL reset_mid: got %h/%h v=%b%b fe=%b%b ovr=%b%b, expected all 0",
               dout_m, dout_l, valid_m, valid_l, ferr_m, ferr_l, ovr_m, ovr_l);
    end
    model_reset();
    ferr_seen = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    send_word(8'hFF, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (dout_m !== 8'hFF || valid_m !== 1'b1 || ferr_seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_recover: got dout=%h valid=%b ferr_seen=%b, expected ff 1 0",
               dout_m, valid_m, ferr_seen);
    end
  endtask

  task automatic test_random();
    int len, gap;
    for (int n = 0; n < 60; n++) begin
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8 * $urandom_range(1, 2);
      gap = $urandom_range(0, 2);
      for (int j = 0; j < len + gap; j++) begin
        step(1'($urandom), (j < len), 1'($urandom));
        checks++;
        if ({dout_m, dout_l, valid_m, valid_l, ferr_m, ferr_l, ovr_m, ovr_l} !==
            {e_dm, e_dl, e_valid, e_valid, e_ferr, e_ferr, e_ovr, e_ovr}) begin
          errors++;
          $display("FAIL random_cycle: got %h/%h v=%b%b fe=%b%b ovr=%b%b, expected %h/%h v=%b fe=%b ovr=%b",
                   dout_m, dout_l, valid_m, valid_l, ferr_m, ferr_l, ovr_m, ovr_l,
                   e_dm, e_dl, e_valid, e_ferr, e_ovr);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_short_frame();
    test_overrun();
    test_lsb_first();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
